// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    localparam int DEF_HOLD_CYCLES     = 100000;
    localparam int DEF_NUM_STAGES      = 3;
    localparam int DEF_STAGE_GAP       = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1024;

endpackage

// File: rtl/reset_debounce.sv
// Push-button request path: 2-flop synchroniser followed by a debounce counter
// that flips the level only after DEBOUNCE_CYCLES consecutive differing samples.
module reset_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic MCLK_IN,
    input  logic RESET_ALL_IN,
    input  logic ASYNC_IN,
    output logic LEVEL_OUT
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        sync1_d = ASYNC_IN;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_ALL_IN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign LEVEL_OUT = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds CPU and peripheral resets for HOLD_CYCLES, then releases the peripheral
// domains one per STAGE_GAP cycles (bit 0 first) before releasing the CPU.
//
// state   | meaning
// HOLD    | all resets asserted, hold counter running while no request
// RELEASE | peripheral domains being released one by one
// RUN     | CPU released, waiting for a request or reset
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                  MCLK_IN,
    input  logic                  RESET_ALL_IN,
    input  logic                  RESET_REQ_IN,
    output logic                  RESET,
    output logic                  HALT,
    output logic                  RUN,
    output logic [NUM_STAGES-1:0] STAGE_RESET,
    output logic [1:0]            STATE
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int IDX_W  = $clog2(NUM_STAGES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(NUM_STAGES);

    logic req_level;

    seq_state_e            state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      idx_next;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  reset_q, reset_d;
    logic                  halt_q, halt_d;
    logic                  run_q, run_d;

    reset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .MCLK_IN     (MCLK_IN),
        .RESET_ALL_IN(RESET_ALL_IN),
        .ASYNC_IN    (RESET_REQ_IN),
        .LEVEL_OUT   (req_level)
    );

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        idx_d         = idx_q;
        idx_next      = idx_q + 1'b1;
        stage_reset_d = stage_reset_q;
        reset_d       = reset_q;
        halt_d        = halt_q;
        run_d         = run_q;

        // A held request overrides everything: assert all at once, release later in order.
        if (req_level) begin
            state_d       = ST_HOLD;
            hold_cnt_d    = '0;
            gap_cnt_d     = '0;
            idx_d         = '0;
            stage_reset_d = '1;
            reset_d       = 1'b1;
            halt_d        = 1'b1;
            run_d         = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d          = ST_RELEASE;
                        hold_cnt_d       = '0;
                        gap_cnt_d        = '0;
                        idx_d            = '0;
                        stage_reset_d[0] = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        idx_d     = idx_next;
                        if (idx_next == IDX_END) begin
                            state_d = ST_RUN;
                            reset_d = 1'b0;
                            halt_d  = 1'b0;
                            run_d   = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_STAGES; i++) begin
                                if (idx_next == IDX_W'(i)) begin
                                    stage_reset_d[i] = 1'b0;
                                end
                            end
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET_ALL_IN) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            stage_reset_q <= '1;
            reset_q       <= 1'b1;
            halt_q        <= 1'b1;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            stage_reset_q <= stage_reset_d;
            reset_q       <= reset_d;
            halt_q        <= halt_d;
            run_q         <= run_d;
        end
    end

    assign RESET       = reset_q;
    assign HALT        = halt_q;
    assign RUN         = run_q;
    assign STAGE_RESET = stage_reset_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timeline scenarios plus
// randomized request/reset traffic, all compared against a timeline model.
module tb_reset_sequencer;

    localparam int H = 10;
    localparam int N = 3;
    localparam int G = 4;
    localparam int D = 5;

    logic         clk = 1'b0;
    logic         rst_all;
    logic         req;
    logic         reset_o;
    logic         halt_o;
    logic         run_o;
    logic [N-1:0] stage_reset_o;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;

    // Model: synchroniser samples, debounce run length, level, and edges since hold start.
    int m_s1, m_s2, m_lvl, m_rl, m_t;

    always #5 clk = ~clk;

    reset_sequencer #(
        .HOLD_CYCLES    (H),
        .NUM_STAGES     (N),
        .STAGE_GAP      (G),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .MCLK_IN     (clk),
        .RESET_ALL_IN(rst_all),
        .RESET_REQ_IN(req),
        .RESET       (reset_o),
        .HALT        (halt_o),
        .RUN         (run_o),
        .STAGE_RESET (stage_reset_o),
        .STATE       (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int old_lvl;
        if (rst_all) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rl = 0; m_t = 0;
        end else begin
            old_lvl = m_lvl;
            if (m_s2 != m_lvl) begin
                m_rl++;
                if (m_rl == D) begin
                    m_lvl = 1 - m_lvl;
                    m_rl  = 0;
                end
            end else begin
                m_rl = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(req);
            if (old_lvl != 0) m_t = 0;
            else if (m_t < 100000) m_t++;
        end
    endfunction

    function automatic int exp_released();
        int r;
        if (m_t < H) return 0;
        r = (m_t - H) / G + 1;
        return (r > N) ? N : r;
    endfunction

    task automatic compare_all();
        int rel;
        int run_e;
        int sr;
        int st;
        rel   = exp_released();
        run_e = (m_t >= H + N * G) ? 1 : 0;
        sr    = ((1 << N) - 1) & ~((1 << rel) - 1);
        st    = run_e ? 2 : ((m_t >= H) ? 1 : 0);
        chk("stage_reset", 32'(stage_reset_o), 32'(sr));
        chk("reset", 32'(reset_o), 32'(1 - run_e));
        chk("halt", 32'(halt_o), 32'(1 - run_e));
        chk("run", 32'(run_o), 32'(run_e));
        chk("state", 32'(state_o), 32'(st));
        chk("level", 32'(dut.req_level), 32'(m_lvl));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_run(input string tag, input int expect_edges);
        int n;
        n = 0;
        while (run_o !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(expect_edges));
    endtask

    initial begin
        int first;
        int n;
        int hold_left;

        rst_all = 1'b1;
        req     = 1'b0;
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_rl = 0; m_t = 0;

        // Power-up
        repeat (3) step();
        chk("reset_stage", 32'(stage_reset_o), 32'h7);
        chk("reset_state", 32'(state_o), 32'h0);
        rst_all = 1'b0;
        wait_run("powerup_run_edge", H + N * G);

        // Glitch shorter than the debounce window
        req = 1'b1;
        repeat (4) step();
        req = 1'b0;
        repeat (15) step();
        chk("glitch_run", 32'(run_o), 32'h1);

        // Push-button held for 20 cycles
        req   = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (first == 0 && run_o == 1'b0) first = i;
        end
        chk("button_assert_edge", 32'(first), 32'(3 + D));
        req = 1'b0;
        n = 0;
        while (dut.req_level !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("button_level_fall", 32'(dut.req_level), 32'h0);
        wait_run("button_run_edge", H + N * G);

        // Reset pulse mid-release
        rst_all = 1'b1;
        step();
        rst_all = 1'b0;
        n = 0;
        while (!(exp_released() == 2 && m_t < H + N * G) && n < 60) begin
            step();
            n++;
        end
        chk("midrel_stage_before", 32'(stage_reset_o), 32'h4);
        rst_all = 1'b1;
        step();
        chk("midrel_stage", 32'(stage_reset_o), 32'h7);
        chk("midrel_reset", 32'(reset_o), 32'h1);
        chk("midrel_state", 32'(state_o), 32'h0);
        rst_all = 1'b0;
        wait_run("midrel_run_edge", H + N * G);

        // Reset collides with the edge on which the level would rise
        req = 1'b1;
        n = 0;
        while (!(m_s2 == 1 && m_lvl == 0 && m_rl == D - 1) && n < 30) begin
            step();
            n++;
        end
        chk("collision_setup", 32'(m_rl), 32'(D - 1));
        rst_all = 1'b1;
        req     = 1'b0;
        step();
        chk("collision_level", 32'(dut.req_level), 32'h0);
        rst_all = 1'b0;
        wait_run("collision_run_edge", H + N * G);

        // Randomized request and reset traffic
        hold_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_left == 0) begin
                req       = 1'($urandom_range(0, 1));
                hold_left = int'($urandom_range(1, 12));
            end
            rst_all = ($urandom_range(0, 39) == 0);
            step();
            hold_left--;
        end
        rst_all = 1'b0;
        req     = 1'b0;
        repeat (60) step();
        chk("final_run", 32'(run_o), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
